id_ex_stage: RTL

- ID/EX pipeline stage directly upstream of the ALU.
- Registers decoded operands and control from ID, then applies EX/MEM and MEM/WB operand forwarding combinationally to drive alu_in1/alu_in2/alu_op_ctrl/shamt/branch/branch_type.
- Detects load-use hazards (inserts a bubble, stalls IF/ID) and handles branch flush and downstream hold.

---
 rtl/alu_op_pkg.sv | 31 +++
 rtl/fwd_unit.sv | 32 +++
 rtl/id_ex_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_pkg.sv
// Shared ALU opcode, forwarding-select types and helpers for the ID/EX stage.
package alu_op_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A writer targets a given source register; x0 never counts as a hit.
    function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand forwarding for one source register.
module fwd_unit
    import alu_op_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic [4:0]      exmem_rd_addr,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd_addr,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_wdata,
    output logic [XLEN-1:0] fwd_data,
    output fwd_sel_t        fwd_sel
);

    // Youngest producer wins: EX/MEM before MEM/WB before the registered value.
    always_comb begin
        fwd_data = reg_data;
        fwd_sel  = FWD_NONE;
        if (reg_hit(exmem_reg_write, exmem_rd_addr, rs_addr)) begin
            fwd_data = exmem_result;
            fwd_sel  = FWD_EXMEM;
        end else if (reg_hit(memwb_reg_write, memwb_rd_addr, rs_addr)) begin
            fwd_data = memwb_wdata;
            fwd_sel  = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble, flush and hold.
module id_ex_stage
    import alu_op_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic            id_use_pc,
    input  logic            id_shamt_from_imm,
    input  alu_op_t         id_alu_op,
    input  logic            id_branch,
    input  logic [2:0]      id_branch_type,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [4:0]      exmem_rd_addr,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd_addr,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_wdata,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            stall_id,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output alu_op_t         alu_op_ctrl,
    output logic [4:0]      shamt,
    output logic            branch,
    output logic [2:0]      branch_type,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_store_data
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            use_imm_q, use_imm_d, use_pc_q, use_pc_d;
    logic            shamt_imm_q, shamt_imm_d;
    alu_op_t         alu_op_q, alu_op_d;
    logic            branch_q, branch_d;
    logic [2:0]      btype_q, btype_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    fwd_sel_t        sel_rs1, sel_rs2;
    logic            load_use;

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr        (rs1_addr_q),
        .reg_data       (rs1_data_q),
        .exmem_rd_addr  (exmem_rd_addr),
        .exmem_reg_write(exmem_reg_write),
        .exmem_result   (exmem_result),
        .memwb_rd_addr  (memwb_rd_addr),
        .memwb_reg_write(memwb_reg_write),
        .memwb_wdata    (memwb_wdata),
        .fwd_data       (fwd_rs1),
        .fwd_sel        (sel_rs1)
    );

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr        (rs2_addr_q),
        .reg_data       (rs2_data_q),
        .exmem_rd_addr  (exmem_rd_addr),
        .exmem_reg_write(exmem_reg_write),
        .exmem_result   (exmem_result),
        .memwb_rd_addr  (memwb_rd_addr),
        .memwb_reg_write(memwb_reg_write),
        .memwb_wdata    (memwb_wdata),
        .fwd_data       (fwd_rs2),
        .fwd_sel        (sel_rs2)
    );

    // Hazard detection and IF/ID stall; a redirect makes stalling pointless.
    always_comb begin
        load_use = id_valid && valid_q && mem_read_q && (rd_q != REG_X0) &&
                   ((id_uses_rs1 && (id_rs1_addr == rd_q)) ||
                    (id_uses_rs2 && (id_rs2_addr == rd_q)));
        stall_id = flush ? 1'b0 : (load_use || ex_hold);
    end

    // Next-state for the stage register: flush > hold > bubble > capture.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        use_pc_d    = use_pc_q;
        shamt_imm_d = shamt_imm_q;
        alu_op_d    = alu_op_q;
        branch_d    = branch_q;
        btype_d     = btype_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            branch_d    = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (ex_hold) begin
            // Absorb any producer retiring now so its value survives the freeze.
            if (sel_rs1 != FWD_NONE) rs1_data_d = fwd_rs1;
            if (sel_rs2 != FWD_NONE) rs2_data_d = fwd_rs2;
        end else if (load_use) begin
            valid_d     = 1'b0;
            branch_d    = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            use_pc_d    = id_use_pc;
            shamt_imm_d = id_shamt_from_imm;
            alu_op_d    = id_alu_op;
            branch_d    = id_branch;
            btype_d     = id_branch_type;
            rd_d        = id_rd_addr;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= RESET_PC;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            use_pc_q    <= 1'b0;
            shamt_imm_q <= 1'b0;
            alu_op_q    <= ALU_ADD;
            branch_q    <= 1'b0;
            btype_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            use_pc_q    <= use_pc_d;
            shamt_imm_q <= shamt_imm_d;
            alu_op_q    <= alu_op_d;
            branch_q    <= branch_d;
            btype_q     <= btype_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Operand muxing and valid-qualified control outputs.
    always_comb begin
        ex_valid      = valid_q;
        ex_pc         = pc_q;
        alu_in1       = use_pc_q ? pc_q : fwd_rs1;
        alu_in2       = use_imm_q ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
        shamt         = shamt_imm_q ? imm_q[4:0] : fwd_rs2[4:0];
        alu_op_ctrl   = alu_op_q;
        branch_type   = btype_q;
        ex_rd_addr    = rd_q;
        branch        = valid_q && branch_q;
        ex_reg_write  = valid_q && reg_write_q;
        ex_mem_read   = valid_q && mem_read_q;
        ex_mem_write  = valid_q && mem_write_q;
    end

endmodule
